// File: rtl/uart_pkg.sv
// Shared UART definitions for the debug-link transmit and receive paths.
package uart_pkg;

    localparam logic [13:0] UART_BAUD_DIV_115200 = 14'd433;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_rx_state_t;

    // Start-bit centre offset: integer half of the bit-period divider.
    function automatic logic [13:0] uart_half_div(input logic [13:0] div);
        return {1'b0, div[13:1]};
    endfunction

endpackage

// File: rtl/uart_rx_path.sv
// 8N1 UART receiver: synchronises the line, validates the start bit and
// samples each bit at its centre, strobing good bytes and framing errors.
module uart_rx_path
    import uart_pkg::*;
#(
    parameter logic [13:0] BAUD_DIV = UART_BAUD_DIV_115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] uart_rx_data_o,
    output logic       uart_rx_done_o,
    output logic       uart_rx_err_o,
    output logic       uart_rx_busy_o
);

    localparam logic [13:0] HALF_DIV = uart_half_div(BAUD_DIV);

    uart_rx_state_t state_q, state_d;

    logic        rx_s1_q, rx_s_q, rx_d_q;
    logic [13:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  warm_q, warm_d;
    logic        armed_q, armed_d;
    logic        fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_d_q     <= 1'b1;
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            warm_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx_i;
            rx_s_q     <= rx_s1_q;
            rx_d_q     <= rx_s_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            warm_q     <= warm_d;
            armed_q    <= armed_d;
        end
    end

    // The sync flops hold reset values for three cycles; only arm edge
    // detection once the line has genuinely been seen idle-high, so a line
    // held low through reset cannot fake a start edge.
    always_comb begin
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd3) & rx_s_q & rx_d_q);
        fall    = armed_q & ~rx_s_q & rx_d_q;
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_cnt_q == HALF_DIV) begin
                    baud_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            StData: begin
                if (baud_cnt_q == BAUD_DIV) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            StStop: begin
                // Leave at the stop-bit centre so a back-to-back start edge is caught.
                if (baud_cnt_q == BAUD_DIV) begin
                    baud_cnt_d = '0;
                    state_d    = StIdle;
                    if (rx_s_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = '0;
            end
        endcase
    end

    assign uart_rx_data_o = data_q;
    assign uart_rx_done_o = done_q;
    assign uart_rx_err_o  = err_q;
    assign uart_rx_busy_o = (state_q != StIdle);

    a_strobe_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        !(done_q && err_q));
    a_strobe_gap: assert property (@(posedge clk_i) disable iff (rst_i)
        (done_q || err_q) |=> !(done_q || err_q));

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path at 16 clocks per bit.
module tb_uart_rx_path;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       uart_rx_i = 1'b1;
    logic [7:0] uart_rx_data_o;
    logic       uart_rx_done_o;
    logic       uart_rx_err_o;
    logic       uart_rx_busy_o;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cyc = 0;
    int last_err_cyc = 0;
    logic busy_on_strobe = 1'b0;
    logic [7:0] done_q[$];
    int done_cyc_q[$];

    uart_rx_path #(
        .BAUD_DIV(14'd15)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .uart_rx_i     (uart_rx_i),
        .uart_rx_data_o(uart_rx_data_o),
        .uart_rx_done_o(uart_rx_done_o),
        .uart_rx_err_o (uart_rx_err_o),
        .uart_rx_busy_o(uart_rx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (uart_rx_busy_o) busy_cyc <= busy_cyc + 1;
        if (uart_rx_done_o) begin
            done_cnt <= done_cnt + 1;
            done_q.push_back(uart_rx_data_o);
            done_cyc_q.push_back(cyc);
            busy_on_strobe <= busy_on_strobe | uart_rx_busy_o;
        end
        if (uart_rx_err_o) begin
            err_cnt <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
    end

    // Puts the next line edge 7 ns after a rising clock edge.
    task automatic align();
        @(posedge clk_i);
        #7;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        uart_rx_i = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            #(per);
        end
        uart_rx_i = stop_bit;
        #(per);
        uart_rx_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        uart_rx_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (uart_rx_data_o !== 8'h00) begin errors++;
            $display("FAIL reset_data: got %h expected 00", uart_rx_data_o); end
        checks++; if (uart_rx_done_o !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b expected 0", uart_rx_done_o); end
        checks++; if (uart_rx_err_o !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b expected 0", uart_rx_err_o); end
        checks++; if (uart_rx_busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", uart_rx_busy_o); end
        rst_i = 1'b0;
        // Line still low after reset: no frame may start.
        repeat (40) @(negedge clk_i);
        checks++; if (busy_cyc !== 0) begin errors++;
            $display("FAIL held_low_busy: got %0d busy cycles expected 0", busy_cyc); end
        checks++; if (done_cnt !== 0) begin errors++;
            $display("FAIL held_low_done: got %0d expected 0", done_cnt); end
        checks++; if (err_cnt !== 0) begin errors++;
            $display("FAIL held_low_err: got %0d expected 0", err_cnt); end
        uart_rx_i = 1'b1;
        repeat (20) @(posedge clk_i);
    endtask

    task automatic test_single();
        int c, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        align();
        c = cyc;
        fork
            send_frame(8'hA5, 1'b1, 160);
            begin
                @(negedge clk_i);
                @(negedge clk_i);
                checks++; if (uart_rx_busy_o !== 1'b0) begin errors++;
                    $display("FAIL single_busy_detect: got %b expected 0", uart_rx_busy_o); end
                @(negedge clk_i);
                checks++; if (uart_rx_busy_o !== 1'b1) begin errors++;
                    $display("FAIL single_busy_rise: got %b expected 1", uart_rx_busy_o); end
            end
        join
        repeat (20) @(posedge clk_i);
        checks++; if (done_cnt !== d0 + 1) begin errors++;
            $display("FAIL single_done_count: got %0d expected %0d", done_cnt, d0 + 1); end
        checks++; if (uart_rx_data_o !== 8'hA5) begin errors++;
            $display("FAIL single_data: got %h expected a5", uart_rx_data_o); end
        checks++; if (done_cyc_q.size() == 0 || done_cyc_q[done_cyc_q.size()-1] !== c + 155)
            begin errors++;
            $display("FAIL single_latency: got cycle %0d expected %0d",
                     (done_cyc_q.size() == 0) ? -1 : done_cyc_q[done_cyc_q.size()-1], c + 155); end
        checks++; if (err_cnt !== e0) begin errors++;
            $display("FAIL single_err: got %0d expected %0d", err_cnt, e0); end
        checks++; if (busy_on_strobe !== 1'b0) begin errors++;
            $display("FAIL single_busy_fall: busy high with strobe, expected low"); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int b, e0;
        exp = '{8'h00, 8'hFF, 8'h55};
        b = done_q.size();
        e0 = err_cnt;
        align();
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 160);
        repeat (20) @(posedge clk_i);
        for (int i = 0; i < 3; i++) begin
            checks++; if (done_q.size() <= b + i || done_q[b + i] !== exp[i]) begin errors++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i,
                         (done_q.size() <= b + i) ? 8'hxx : done_q[b + i], exp[i]); end
        end
        checks++; if (done_q.size() !== b + 3) begin errors++;
            $display("FAIL b2b_count: got %0d expected %0d", done_q.size() - b, 3); end
        checks++; if (done_cyc_q.size() < b + 2 || done_cyc_q[b + 1] - done_cyc_q[b] !== 160)
            begin errors++;
            $display("FAIL b2b_spacing: strobe spacing wrong, expected 160 cycles"); end
        checks++; if (err_cnt !== e0) begin errors++;
            $display("FAIL b2b_err: got %0d expected %0d", err_cnt, e0); end
    endtask

    task automatic test_glitch();
        int b0, d0, e0;
        b0 = busy_cyc;
        d0 = done_cnt;
        e0 = err_cnt;
        align();
        uart_rx_i = 1'b0;
        #40;
        uart_rx_i = 1'b1;
        repeat (30) @(posedge clk_i);
        checks++; if (busy_cyc - b0 !== 8) begin errors++;
            $display("FAIL glitch_busy_len: got %0d expected 8", busy_cyc - b0); end
        checks++; if (done_cnt !== d0) begin errors++;
            $display("FAIL glitch_done: got %0d expected %0d", done_cnt, d0); end
        checks++; if (err_cnt !== e0) begin errors++;
            $display("FAIL glitch_err: got %0d expected %0d", err_cnt, e0); end
        checks++; if (uart_rx_data_o !== 8'h55) begin errors++;
            $display("FAIL glitch_data: got %h expected 55", uart_rx_data_o); end
    endtask

    task automatic test_stop_error();
        int c, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        align();
        c = cyc;
        send_frame(8'h3C, 1'b0, 160);
        #320;
        checks++; if (err_cnt !== e0 + 1) begin errors++;
            $display("FAIL stoperr_count: got %0d expected %0d", err_cnt, e0 + 1); end
        checks++; if (last_err_cyc !== c + 155) begin errors++;
            $display("FAIL stoperr_time: got cycle %0d expected %0d", last_err_cyc, c + 155); end
        checks++; if (done_cnt !== d0) begin errors++;
            $display("FAIL stoperr_done: got %0d expected %0d", done_cnt, d0); end
        checks++; if (uart_rx_data_o !== 8'h55) begin errors++;
            $display("FAIL stoperr_data_kept: got %h expected 55", uart_rx_data_o); end
        align();
        send_frame(8'h81, 1'b1, 160);
        repeat (20) @(posedge clk_i);
        checks++; if (done_cnt !== d0 + 1 || uart_rx_data_o !== 8'h81) begin errors++;
            $display("FAIL stoperr_recover: got %h (%0d strobes) expected 81 (1)",
                     uart_rx_data_o, done_cnt - d0); end
        checks++; if (err_cnt !== e0 + 1) begin errors++;
            $display("FAIL stoperr_recover_err: got %0d expected %0d", err_cnt, e0 + 1); end
    endtask

    task automatic test_break();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        align();
        uart_rx_i = 1'b0;
        repeat (300) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (err_cnt !== e0 + 1) begin errors++;
            $display("FAIL break_err: got %0d expected %0d", err_cnt, e0 + 1); end
        checks++; if (done_cnt !== d0) begin errors++;
            $display("FAIL break_done: got %0d expected %0d", done_cnt, d0); end
        checks++; if (uart_rx_busy_o !== 1'b0) begin errors++;
            $display("FAIL break_idle: got busy %b expected 0", uart_rx_busy_o); end
        uart_rx_i = 1'b1;
        repeat (20) @(posedge clk_i);
    endtask

    task automatic test_reset_mid_frame();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        align();
        fork
            send_frame(8'hC3, 1'b1, 160);
            begin
                #850;
                @(negedge clk_i);
                rst_i = 1'b1;
                @(negedge clk_i);
                checks++; if (uart_rx_data_o !== 8'h00) begin errors++;
                    $display("FAIL midrst_data: got %h expected 00", uart_rx_data_o); end
                checks++; if (uart_rx_busy_o !== 1'b0) begin errors++;
                    $display("FAIL midrst_busy: got %b expected 0", uart_rx_busy_o); end
                checks++; if (uart_rx_done_o !== 1'b0 || uart_rx_err_o !== 1'b0) begin errors++;
                    $display("FAIL midrst_strobes: got done=%b err=%b expected 0 0",
                             uart_rx_done_o, uart_rx_err_o); end
                repeat (28) @(negedge clk_i);
                rst_i = 1'b0;
            end
        join
        repeat (30) @(posedge clk_i);
        checks++; if (done_cnt !== d0 || err_cnt !== e0) begin errors++;
            $display("FAIL midrst_silent: got done=%0d err=%0d expected 0 0",
                     done_cnt - d0, err_cnt - e0); end
        align();
        send_frame(8'h12, 1'b1, 160);
        repeat (20) @(posedge clk_i);
        checks++; if (done_cnt !== d0 + 1 || uart_rx_data_o !== 8'h12) begin errors++;
            $display("FAIL midrst_next: got %h (%0d strobes) expected 12 (1)",
                     uart_rx_data_o, done_cnt - d0); end
    endtask

    task automatic test_baud_tolerance();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        align();
        send_frame(8'h96, 1'b1, 155);
        repeat (20) @(posedge clk_i);
        checks++; if (done_cnt !== d0 + 1 || uart_rx_data_o !== 8'h96) begin errors++;
            $display("FAIL fast_baud: got %h (%0d strobes) expected 96 (1)",
                     uart_rx_data_o, done_cnt - d0); end
        align();
        send_frame(8'h96, 1'b1, 165);
        repeat (20) @(posedge clk_i);
        checks++; if (done_cnt !== d0 + 2 || done_q[done_q.size()-1] !== 8'h96) begin errors++;
            $display("FAIL slow_baud: got %h (%0d strobes) expected 96 (2)",
                     uart_rx_data_o, done_cnt - d0); end
        checks++; if (err_cnt !== e0) begin errors++;
            $display("FAIL baud_err: got %0d expected %0d", err_cnt, e0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_stop_error();
        test_break();
        test_reset_mid_frame();
        test_baud_tolerance();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
